// File: rtl/fir_pkg.sv
// Shared types and width helpers for the parametrised time-multiplexed FIR.
package fir_pkg;

  // Controller states: waiting for a sample, or stepping through the taps.
  typedef enum logic [0:0] {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  // Result width that can hold TAPS full-scale products without overflow.
  function automatic int calc_out_w(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Width of the tap index counter.
  function automatic int calc_idx_w(input int taps);
    return (taps > 1) ? $clog2(taps) : 1;
  endfunction

endpackage

// File: rtl/fir_coef_chain.sv
// Coefficient storage: serial shadow chain, active bank used by the MAC, and
// the commit logic that defers a load until the sample in flight has finished.
module fir_coef_chain
  import fir_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int COEF_W = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     shift_en,
  input  logic                     shift_in,
  output logic                     shift_out,
  input  logic                     coef_load,
  input  logic                     idle,
  input  logic                     accept,
  input  logic                     last,
  output logic [TAPS*COEF_W-1:0]   active,
  output logic                     coef_pending
);

  localparam int CHAIN_W = TAPS * COEF_W;

  logic [CHAIN_W-1:0] shadow;

  assign shift_out = shadow[CHAIN_W-1];

  // Serial load: newest bit enters at bit 0, so the first bit ends at c_{TAPS-1} MSB.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow <= '0;
    end else if (shift_en) begin
      shadow <= {shadow[CHAIN_W-2:0], shift_in};
    end
  end

  // Commit shadow to the active bank now when idle, otherwise on the final MAC edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      active       <= '0;
      coef_pending <= 1'b0;
    end else if (last) begin
      // The last product has already used the old coefficient this cycle.
      if (coef_pending || coef_load) begin
        active <= shadow;
      end
      coef_pending <= 1'b0;
    end else if (coef_load) begin
      if (idle && !accept) begin
        active <= shadow;
      end else begin
        coef_pending <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/fir_mac_param.sv
// Parametrised FIR filter evaluated by a single multiply-accumulate unit, one
// tap per cycle, behind a valid/ready sample interface.
module fir_mac_param
  import fir_pkg::*;
#(
  parameter int TAPS   = 4,
  parameter int DATA_W = 8,
  parameter int COEF_W = 8,
  parameter int SIGNED = 0,
  parameter int OUT_W  = calc_out_w(DATA_W, COEF_W, TAPS)
) (
  input  logic              ph1,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  output logic [OUT_W-1:0]  out_data,
  input  logic              shift_en,
  input  logic              shift_in,
  output logic              shift_out,
  input  logic              coef_load,
  output logic              coef_pending
);

  localparam int PROD_W = DATA_W + COEF_W;
  localparam int IDX_W  = calc_idx_w(TAPS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TAPS - 1);

  state_t                   state;
  logic [IDX_W-1:0]         idx;
  logic signed [OUT_W-1:0]  acc;
  logic [TAPS*DATA_W-1:0]   xline;
  logic [TAPS*COEF_W-1:0]   active;
  logic [DATA_W-1:0]        x_sel;
  logic [COEF_W-1:0]        c_sel;
  logic signed [OUT_W-1:0]  term;
  logic signed [OUT_W-1:0]  sum;
  logic                     idle;
  logic                     accept;
  logic                     last;

  // One tap product, extended to the accumulator width according to SIGNED.
  function automatic logic signed [OUT_W-1:0] mac_term(
    input logic [COEF_W-1:0] c,
    input logic [DATA_W-1:0] x
  );
    logic signed [PROD_W-1:0] cs;
    logic signed [PROD_W-1:0] xs;
    logic signed [PROD_W-1:0] p;
    if (SIGNED != 0) begin
      cs = PROD_W'($signed(c));
      xs = PROD_W'($signed(x));
    end else begin
      cs = $signed(PROD_W'(c));
      xs = $signed(PROD_W'(x));
    end
    p = cs * xs;
    if (SIGNED != 0) begin
      return OUT_W'(p);
    end else begin
      return $signed(OUT_W'($unsigned(p)));
    end
  endfunction

  assign idle   = (state == IDLE);
  assign accept = in_valid & in_ready;
  assign last   = (state == MAC) && (idx == LAST_IDX);

  fir_coef_chain #(
    .TAPS   (TAPS),
    .COEF_W (COEF_W)
  ) u_coef (
    .clk          (ph1),
    .rst          (reset),
    .shift_en     (shift_en),
    .shift_in     (shift_in),
    .shift_out    (shift_out),
    .coef_load    (coef_load),
    .idle         (idle),
    .accept       (accept),
    .last         (last),
    .active       (active),
    .coef_pending (coef_pending)
  );

  // Select the coefficient and delay-line sample addressed by the tap index.
  always_comb begin
    c_sel = '0;
    x_sel = '0;
    for (int k = 0; k < TAPS; k++) begin
      if (idx == IDX_W'(k)) begin
        c_sel = active[k*COEF_W +: COEF_W];
        x_sel = xline[k*DATA_W +: DATA_W];
      end
    end
  end

  assign term = mac_term(c_sel, x_sel);
  assign sum  = acc + term;

  // Controller, delay line and accumulator: accept in IDLE, one tap per MAC edge.
  always_ff @(posedge ph1) begin
    if (reset) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_data  <= '0;
      acc       <= '0;
      idx       <= '0;
      xline     <= '0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            xline    <= {xline[(TAPS-1)*DATA_W-1:0], in_data};
            acc      <= '0;
            idx      <= '0;
            in_ready <= 1'b0;
            state    <= MAC;
          end
        end
        MAC: begin
          acc <= sum;
          idx <= idx + 1'b1;
          if (idx == LAST_IDX) begin
            out_data  <= sum;
            out_valid <= 1'b1;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          state    <= IDLE;
          in_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_param.sv
// Directed bench for fir_mac_param: an unsigned 4-tap instance and a signed
// 3-tap instance share the stimulus inputs; each scenario checks its own outputs.
module tb_fir_mac_param;

  logic       ph1 = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_data = 8'd0;
  logic       shift_en = 1'b0;
  logic       shift_in = 1'b0;
  logic       coef_load = 1'b0;

  logic        in_ready_u, out_valid_u, shift_out_u, coef_pending_u;
  logic [17:0] out_data_u;
  logic        in_ready_s, out_valid_s, shift_out_s, coef_pending_s;
  logic [17:0] out_data_s;

  int n_checks = 0;
  int n_fail = 0;

  always #5 ph1 = ~ph1;

  fir_mac_param #(.TAPS(4), .DATA_W(8), .COEF_W(8), .SIGNED(0)) dut_u (
    .ph1(ph1), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_u), .in_data(in_data),
    .out_valid(out_valid_u), .out_data(out_data_u),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(shift_out_u),
    .coef_load(coef_load), .coef_pending(coef_pending_u)
  );

  fir_mac_param #(.TAPS(3), .DATA_W(8), .COEF_W(8), .SIGNED(1)) dut_s (
    .ph1(ph1), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready_s), .in_data(in_data),
    .out_valid(out_valid_s), .out_data(out_data_s),
    .shift_en(shift_en), .shift_in(shift_in), .shift_out(shift_out_s),
    .coef_load(coef_load), .coef_pending(coef_pending_s)
  );

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    shift_en = 1'b0;
    coef_load = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // c_{taps-1} MSB goes in first, c_0 LSB last.
  task automatic shift_coefs(input int taps, input int c0, input int c1, input int c2, input int c3);
    int c[4];
    logic [7:0] b;
    c[0] = c0; c[1] = c1; c[2] = c2; c[3] = c3;
    for (int k = taps - 1; k >= 0; k--) begin
      b = 8'(c[k]);
      for (int i = 7; i >= 0; i--) begin
        shift_en = 1'b1;
        shift_in = b[i];
        tick();
      end
    end
    shift_en = 1'b0;
    shift_in = 1'b0;
  endtask

  task automatic load_coefs(input int taps, input int c0, input int c1, input int c2, input int c3);
    shift_coefs(taps, c0, c1, c2, c3);
    coef_load = 1'b1;
    tick();
    coef_load = 1'b0;
  endtask

  // Offer one sample, return the result and the number of edges from accept to out_valid.
  task automatic send_sample(input bit sgn, input int v, output logic [17:0] res, output int lat);
    int n;
    n = 0;
    res = '0;
    lat = -1;
    while (!(sgn ? in_ready_s : in_ready_u) && n < 20) begin
      tick();
      n++;
    end
    in_valid = 1'b1;
    in_data = 8'(v);
    tick();
    in_valid = 1'b0;
    n = 0;
    while (n < 20) begin
      tick();
      n++;
      if (sgn ? out_valid_s : out_valid_u) begin
        res = sgn ? out_data_s : out_data_u;
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: no out_valid within 20 edges of sample %0d", v);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    n_checks++; if (in_ready_u !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b, required 1", in_ready_u); end
    n_checks++; if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b, required 0", out_valid_u); end
    n_checks++; if (out_data_u !== 18'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d, required 0", out_data_u); end
    n_checks++; if (coef_pending_u !== 1'b0) begin n_fail++; $display("FAIL reset_coef_pending: got %b, required 0", coef_pending_u); end
    n_checks++; if (shift_out_u !== 1'b0) begin n_fail++; $display("FAIL reset_shift_out: got %b, required 0", shift_out_u); end
    n_checks++; if (coef_pending_s !== 1'b0) begin n_fail++; $display("FAIL reset_coef_pending_s: got %b, required 0", coef_pending_s); end
  endtask

  task automatic test_basic();
    int smp[4] = '{10, 20, 30, 40};
    int exp_v[4] = '{10, 40, 100, 200};
    logic [17:0] r;
    int lat;
    apply_reset();
    load_coefs(4, 1, 2, 3, 4);
    for (int i = 0; i < 4; i++) begin
      send_sample(1'b0, smp[i], r, lat);
      n_checks++;
      if (r !== 18'(exp_v[i])) begin n_fail++; $display("FAIL basic_result%0d: got %0d, required %0d", i, r, exp_v[i]); end
    end
  endtask

  task automatic test_impulse();
    int smp[5] = '{1, 0, 0, 0, 0};
    int exp_v[5] = '{5, 6, 7, 8, 0};
    logic [17:0] r;
    int lat;
    apply_reset();
    load_coefs(4, 5, 6, 7, 8);
    for (int i = 0; i < 5; i++) begin
      send_sample(1'b0, smp[i], r, lat);
      n_checks++;
      if (r !== 18'(exp_v[i])) begin n_fail++; $display("FAIL impulse_result%0d: got %0d, required %0d", i, r, exp_v[i]); end
      n_checks++;
      if (lat != 4) begin n_fail++; $display("FAIL impulse_latency%0d: got %0d edges, required 4", i, lat); end
    end
  endtask

  task automatic test_max();
    int exp_v[4] = '{65025, 130050, 195075, 260100};
    logic [17:0] r;
    int lat;
    apply_reset();
    load_coefs(4, 255, 255, 255, 255);
    n_checks++; if (shift_out_u !== 1'b1) begin n_fail++; $display("FAIL max_shift_out: got %b, required 1", shift_out_u); end
    for (int i = 0; i < 4; i++) begin
      send_sample(1'b0, 255, r, lat);
      n_checks++;
      if (r !== 18'(exp_v[i])) begin n_fail++; $display("FAIL max_result%0d: got %0d, required %0d", i, r, exp_v[i]); end
    end
  endtask

  task automatic test_deferred();
    logic [17:0] r;
    int lat;
    apply_reset();
    load_coefs(4, 1, 1, 1, 1);
    for (int i = 0; i < 4; i++) send_sample(1'b0, 10, r, lat);
    n_checks++; if (r !== 18'd40) begin n_fail++; $display("FAIL defer_prefill: got %0d, required 40", r); end
    shift_coefs(4, 2, 2, 2, 2);
    in_valid = 1'b1;
    in_data = 8'd10;
    tick();                     // accept edge E
    in_valid = 1'b0;
    tick();                     // E+1
    coef_load = 1'b1;
    tick();                     // E+2: load requested mid-MAC
    coef_load = 1'b0;
    n_checks++; if (coef_pending_u !== 1'b1) begin n_fail++; $display("FAIL defer_pending_e2: got %b, required 1", coef_pending_u); end
    tick();                     // E+3
    n_checks++; if (coef_pending_u !== 1'b1) begin n_fail++; $display("FAIL defer_pending_e3: got %b, required 1", coef_pending_u); end
    n_checks++; if (out_valid_u !== 1'b0) begin n_fail++; $display("FAIL defer_early_valid: got %b, required 0", out_valid_u); end
    tick();                     // E+4: final MAC edge
    n_checks++; if (coef_pending_u !== 1'b0) begin n_fail++; $display("FAIL defer_pending_clear: got %b, required 0", coef_pending_u); end
    n_checks++; if (out_valid_u !== 1'b1) begin n_fail++; $display("FAIL defer_valid: got %b, required 1", out_valid_u); end
    n_checks++; if (out_data_u !== 18'd40) begin n_fail++; $display("FAIL defer_old_coefs: got %0d, required 40", out_data_u); end
    send_sample(1'b0, 10, r, lat);
    n_checks++; if (r !== 18'd80) begin n_fail++; $display("FAIL defer_new_coefs: got %0d, required 80", r); end
  endtask

  task automatic test_reset_mid_mac();
    logic [17:0] r;
    int lat;
    int seen;
    apply_reset();
    load_coefs(4, 1, 2, 3, 4);
    send_sample(1'b0, 3, r, lat);
    n_checks++; if (r !== 18'd3) begin n_fail++; $display("FAIL rstmid_pre: got %0d, required 3", r); end
    in_valid = 1'b1;
    in_data = 8'd50;
    tick();                     // accept edge E
    in_valid = 1'b0;
    coef_load = 1'b1;
    tick();                     // E+1: first MAC edge, load deferred
    coef_load = 1'b0;
    n_checks++; if (coef_pending_u !== 1'b1) begin n_fail++; $display("FAIL rstmid_pending_set: got %b, required 1", coef_pending_u); end
    reset = 1'b1;
    tick();                     // E+2: reset on second MAC cycle
    reset = 1'b0;
    n_checks++; if (in_ready_u !== 1'b1) begin n_fail++; $display("FAIL rstmid_in_ready: got %b, required 1", in_ready_u); end
    n_checks++; if (out_data_u !== 18'd0) begin n_fail++; $display("FAIL rstmid_out_data: got %0d, required 0", out_data_u); end
    n_checks++; if (coef_pending_u !== 1'b0) begin n_fail++; $display("FAIL rstmid_pending_clear: got %b, required 0", coef_pending_u); end
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid_u === 1'b1) seen++;
      tick();
    end
    n_checks++; if (seen != 0) begin n_fail++; $display("FAIL rstmid_no_valid: got %0d strobes, required 0", seen); end
    load_coefs(4, 1, 0, 0, 0);
    send_sample(1'b0, 7, r, lat);
    n_checks++; if (r !== 18'd7) begin n_fail++; $display("FAIL rstmid_after: got %0d, required 7", r); end
  endtask

  task automatic test_signed();
    int smp[3] = '{-4, 5, 6};
    int exp_v[3] = '{4, -13, 16};
    logic [17:0] r;
    int lat;
    apply_reset();
    load_coefs(3, -1, 2, -3, 0);
    n_checks++; if (shift_out_s !== 1'b1) begin n_fail++; $display("FAIL signed_shift_out: got %b, required 1", shift_out_s); end
    for (int i = 0; i < 3; i++) begin
      send_sample(1'b1, smp[i], r, lat);
      n_checks++;
      if (r !== 18'(exp_v[i])) begin n_fail++; $display("FAIL signed_result%0d: got %0d, required %0d", i, $signed(r), exp_v[i]); end
    end
    apply_reset();
    load_coefs(3, -128, 0, 0, 0);
    send_sample(1'b1, -128, r, lat);
    n_checks++; if (r !== 18'd16384) begin n_fail++; $display("FAIL signed_minmin: got %0d, required 16384", $signed(r)); end
    send_sample(1'b1, 0, r, lat);
    n_checks++; if (r !== 18'd0) begin n_fail++; $display("FAIL signed_flush: got %0d, required 0", $signed(r)); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_impulse();
    test_max();
    test_deferred();
    test_reset_mid_mac();
    test_signed();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit, required completion");
    $fatal(1, "watchdog");
  end

endmodule
